// File: rtl/dmem_resp_if.sv
// rtl/dmem_resp_if.sv - request/response bus between the MEM stage, the data memory and WB
//
// Purpose: groups the MEM-stage request handshake and the WB-stage response
// handshake into one bundle.
// Ports (signals):
//   req_valid, req_ready                    request handshake
//   req_we, req_addr, req_wdata,
//   req_size, req_unsigned                  request payload
//   rsp_valid, rsp_ready                    response handshake
//   rsp_rdata, rsp_err                      response payload
// Modports: master = requester / response consumer, slave = data memory.

interface dmem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - fixed-latency data memory with sized, extended loads and fault reporting
//
// Purpose: accepts one load/store at a time, performs the memory access
// LATENCY cycles after acceptance and holds the response until WB takes it.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  dmem_resp_if.slave: request and response handshakes and payloads
// Parameters:
//   MEM_WORDS  number of 32-bit words of storage
//   LATENCY    accept-to-rsp_valid cycles, 1..15

module dmem_resp #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  dmem_resp_if.slave  bus
);

  localparam int         IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  // Counter counts the WAIT cycles remaining after the first one.
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Storage is never reset; contents survive rst.
  logic [31:0] mem [MEM_WORDS];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic        we_q,    we_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q,  size_d;
  logic        uns_q,   uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q,   err_d;

  logic        req_ready;

  // Access view: the request the memory acts on this cycle. With LATENCY=1
  // the access happens on the accepting edge, so it must come straight from
  // the bus; otherwise it comes from the latched copy.
  logic        acc_go;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [1:0]  acc_size;
  logic        acc_uns;
  logic        acc_fault;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0] rd_word;
  logic [31:0] wr_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_data;
  logic [31:0] acc_rdata;

  always_comb begin
    acc_go    = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_size  = size_q;
    acc_uns   = uns_q;
    if ((LATENCY == 1) && (state_q == IDLE) && bus.req_valid) begin
      acc_go    = 1'b1;
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_size  = bus.req_size;
      acc_uns   = bus.req_unsigned;
    end else if ((state_q == WAIT) && (cnt_q == 4'd0)) begin
      acc_go = 1'b1;
    end
  end

  always_comb begin
    acc_fault = 1'b0;
    case (acc_size)
      2'b00:   acc_fault = 1'b0;
      2'b01:   acc_fault = acc_addr[0];
      2'b10:   acc_fault = (acc_addr[1:0] != 2'b00);
      default: acc_fault = 1'b1;
    endcase
    if ({2'b00, acc_addr[31:2]} >= 32'(MEM_WORDS)) begin
      acc_fault = 1'b1;
    end
  end

  assign acc_idx = acc_addr[IDX_W+1:2];
  assign rd_word = mem[acc_idx];

  // Load lane extraction and extension.
  always_comb begin
    case (acc_addr[1:0])
      2'b00:   rd_byte = rd_word[7:0];
      2'b01:   rd_byte = rd_word[15:8];
      2'b10:   rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (acc_size)
      2'b00:   ld_data = acc_uns ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   ld_data = acc_uns ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: ld_data = rd_word;
    endcase
  end

  // Stores are a read-modify-write of the addressed word.
  always_comb begin
    wr_word = rd_word;
    case (acc_size)
      2'b00: begin
        case (acc_addr[1:0])
          2'b00:   wr_word[7:0]   = acc_wdata[7:0];
          2'b01:   wr_word[15:8]  = acc_wdata[7:0];
          2'b10:   wr_word[23:16] = acc_wdata[7:0];
          default: wr_word[31:24] = acc_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (acc_addr[1]) begin
          wr_word[31:16] = acc_wdata[15:0];
        end else begin
          wr_word[15:0] = acc_wdata[15:0];
        end
      end
      default: wr_word = acc_wdata;
    endcase
  end

  // Faulted accesses and stores return zero data.
  assign acc_rdata = (acc_fault || acc_we) ? 32'd0 : ld_data;

  // Reset gating here is what keeps an abandoned store from landing.
  always_ff @(posedge clk) begin
    if (rst && acc_go && acc_we && !acc_fault) begin
      mem[acc_idx] <= wr_word;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    uns_d     = uns_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          cnt_d   = CNT_INIT;
          if (LATENCY > 1) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
            rdata_d = acc_rdata;
            err_d   = acc_fault;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          rdata_d = acc_rdata;
          err_d   = acc_fault;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // Completing here returns to IDLE; req_ready stays low this cycle so
        // the next accept can only happen one cycle later.
        if (bus.rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024: number of 32-bit words of data storage.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to rsp_valid; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  MEM stage request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, LSB-aligned.
REQ-010 SHALL have port req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-011 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 SHALL have port rsp_valid  output  1  response present for the WB stage.
REQ-013 SHALL have port rsp_ready  input  1  WB stage accepts the response.
REQ-014 SHALL have port rsp_rdata  output  32  load result, extended to 32 bits.
REQ-015 SHALL have port rsp_err  output  1  access fault for this response.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 IDLE: a request is accepted on an edge with req_valid=1; at that edge SHALL latch we, addr, wdata, size, unsigned; next state WAIT if LATENCY>1, else RESP.
REQ-018 WAIT: down-counter loaded with LATENCY-2 at acceptance; SHALL move to RESP on the edge where the counter is 0, else decrement.
REQ-019 The memory access SHALL occur on the edge entering RESP, so rsp_valid first rises exactly LATENCY cycles after the accepting edge.
REQ-020 RESP: rsp_valid, rsp_rdata and rsp_err SHALL stay asserted and stable until an edge with rsp_ready=1; that edge moves to IDLE and clears rsp_valid.
REQ-021 A new request SHALL NOT be accepted in the same cycle a response completes; acceptance resumes the cycle after returning to IDLE.
REQ-022 Fault conditions: size=11; half with addr[0]=1; word with addr[1:0]!=00; word index addr[31:2] >= MEM_WORDS.
REQ-023 On fault SHALL set rsp_err=1 and rsp_rdata=0, SHALL NOT modify memory, and SHALL keep the normal LATENCY timing.
REQ-024 Storage is little-endian; byte lane = addr[1:0]; halfword lane = addr[1].
REQ-025 Byte store SHALL write wdata[7:0] to the addressed lane only; half store SHALL write wdata[15:0] to the addressed half only; word store SHALL write all 32 bits.
REQ-026 Loads SHALL extract the addressed byte or half and sign- or zero-extend it per the latched unsigned bit; word loads ignore the unsigned bit.
REQ-027 Store responses SHALL return rsp_rdata=0 with rsp_err=0 when the store is legal.
REQ-028 Request inputs SHALL be ignored outside IDLE; changes on them after acceptance have no effect.

Reset
REQ-029 On an edge with rst=0: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, latched request cleared; req_ready=1 from the following cycle.
REQ-030 Reset mid-operation (WAIT or RESP) SHALL abandon the transaction; a store not yet performed SHALL NOT be written; the pending response is dropped.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-032 With LATENCY=2: word store 0xDEADBEEF to 0x10, then word load from 0x10 -> rsp_valid exactly 2 cycles after each accept; load rdata=0xDEADBEEF, err=0.
REQ-033 Store byte 0x80 to 0x11, then load byte signed and unsigned from 0x11 -> 0xFFFFFF80, then 0x00000080; word at 0x10 = 0xDEAD80EF.
REQ-034 Load half from 0x13 and word from 0x12 -> rsp_err=1, rdata=0; subsequent word load of 0x10 shows memory unchanged.
REQ-035 Hold rsp_ready=0 for 5 cycles during a load response with req_valid=1 throughout -> rsp_valid and data stay stable, req_ready=0, no second accept until 1 cycle after the handshake.
REQ-036 Word store 0x12345678 to 0x20, assert rst=0 in the WAIT cycle, then load 0x20 -> prior contents are returned; rsp_valid=0 and req_ready=1 right after reset.
REQ-037 Word load from byte address 4*MEM_WORDS -> rsp_err=1; with LATENCY=1, back-to-back loads with rsp_ready=1 -> one response every 2 cycles.
